msg_sched_stream: RTL

MSG_SCHED_STREAM -- requirements
Module: msg_sched_stream

---
 rtl/msg_sched_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/msg_sched_stream.sv
// -----------------------------------------------------------------------------
// msg_sched_stream
//
// SHA-2 message schedule generator. It accepts one 16-word message block and
// streams the ROUNDS schedule words Wt, one per consumer handshake. The
// schedule is kept in a 16-word sliding window. Each accepted word shifts the
// window by one position and appends the next Wt at the top.
//
// Parameters
//   WORD_W  word width: 32 (SHA-256) or 64 (SHA-512)
//   ROUNDS  words per block: 64 (WORD_W=32) or 80 (WORD_W=64)
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_n_i        asynchronous active-low reset
//   block_i        16*WORD_W message block; word 0 is in the most significant bits
//   block_v_i      block_i valid
//   block_ready_o  a block can be accepted this cycle
//   wt_o           current schedule word Wt
//   t_o            index t of wt_o
//   wt_v_o         wt_o / t_o valid
//   wt_ready_i     consumer accepts wt_o
//   last_o         high with the final word (t_o = ROUNDS-1)
//
// Configuration
//   MSG_SCHED_STREAM_BACK2BACK_EN  when defined, a new block can be accepted
//   on the same cycle as the final word handshake. The next block then starts
//   with no idle cycle in between. When undefined, blocks are accepted only
//   in IDLE.
// -----------------------------------------------------------------------------
module msg_sched_stream #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [16*WORD_W-1:0] block_i,
   input  logic                 block_v_i,
   output logic                 block_ready_o,
   output logic [WORD_W-1:0]    wt_o,
   output logic [6:0]           t_o,
   output logic                 wt_v_o,
   input  logic                 wt_ready_i,
   output logic                 last_o
);

   localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [WORD_W-1:0] w_q [16];
   logic [6:0]        t_q;
   logic [WORD_W-1:0] w_new;
   logic              last_word;
   logic              blk_hs;
   logic              word_hs;

   // Rotate right. Rotating the doubled word avoids a shift by WORD_W-n.
   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned       n);
      logic [2*WORD_W-1:0] dbl;
      dbl = {x, x} >> (n % WORD_W);
      return dbl[WORD_W-1:0];
   endfunction

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      if (WORD_W == 64)
         return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
      else
         return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      if (WORD_W == 64)
         return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
      else
         return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Window slot 15 receives W[t+16]. The window holds W[t..t+15], so the
   // taps are W[t+14], W[t+9], W[t+1] and W[t]. The sum wraps at WORD_W bits.
   assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

   assign last_word = (t_q == LAST_T);
   assign blk_hs    = block_v_i & block_ready_o;
   assign word_hs   = wt_v_o & wt_ready_i;
   assign wt_o      = w_q[0];
   assign t_o       = t_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wt_v_o        = 1'b0;
      block_ready_o = 1'b0;
      last_o        = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Ready is withheld while reset is asserted.
            block_ready_o = rst_n_i;
            if (block_v_i && rst_n_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            wt_v_o = 1'b1;
            last_o = last_word;
`ifdef MSG_SCHED_STREAM_BACK2BACK_EN
            block_ready_o = last_word & wt_ready_i;
`else
            block_ready_o = 1'b0;
`endif
            // A block taken on the final handshake keeps the FSM in RUN.
            if (wt_ready_i && last_word && !(block_v_i && block_ready_o)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A block load takes priority over the word shift. Both can occur in the
   // same cycle only on the final word of a back-to-back transfer.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int j = 0; j < 16; j++) begin
            w_q[j] <= '0;
         end
         t_q <= '0;
      end else if (blk_hs) begin
         for (int j = 0; j < 16; j++) begin
            w_q[j] <= block_i[(15-j)*WORD_W +: WORD_W];
         end
         t_q <= '0;
      end else if (word_hs) begin
         for (int j = 0; j < 15; j++) begin
            w_q[j] <= w_q[j+1];
         end
         w_q[15] <= w_new;
         t_q     <= t_q + 7'd1;
      end
   end

endmodule
